// File: rtl/btn_click_decoder.sv
// rtl/btn_click_decoder.sv - debounced button with single/double/long-press gesture decoder
// Optional event counter on click_cnt is enabled by defining BTN_CLICK_STATS_EN.
module btn_click_decoder #(
    parameter int CLK_FREQUENCY      = 48000000,
    parameter int BUTTON_LOGIC_LEVEL = 1,
    parameter int DEBOUNCE_MS        = 10,
    parameter int DOUBLE_CLICK_MS    = 400,
    parameter int LONG_PRESS_MS      = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usr_btn,
    output logic       btn_level,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic [7:0] click_cnt
);

    localparam int DEB_CLKS  = CLK_FREQUENCY / 1000 * DEBOUNCE_MS;
    localparam int DC_CLKS   = CLK_FREQUENCY / 1000 * DOUBLE_CLICK_MS;
    localparam int LONG_CLKS = CLK_FREQUENCY / 1000 * LONG_PRESS_MS;
    localparam int DEB_W     = $clog2(DEB_CLKS) + 1;
    localparam int TMR_MAX   = (DC_CLKS > LONG_CLKS) ? DC_CLKS : LONG_CLKS;
    localparam int TMR_W     = $clog2(TMR_MAX) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CLKS - 1);
    localparam logic [TMR_W-1:0] DC_LAST   = TMR_W'(DC_CLKS - 1);
    localparam logic [TMR_W-1:0] LONG_LAST = TMR_W'(LONG_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_HOLD
    } state_t;

    logic             sync1_q, sync2_q;
    logic             pressed;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d, level_prev_q;
    logic             rise, fall;
    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             dbl_q, dbl_d;
    logic             single_hit, long_hit;

    assign pressed = (BUTTON_LOGIC_LEVEL != 0) ? sync2_q : ~sync2_q;
    assign rise    = level_q & ~level_prev_q;
    assign fall    = ~level_q & level_prev_q;

    // Any cycle agreeing with the current level restarts the stability count.
    always_comb begin
        deb_cnt_d = '0;
        level_d   = level_q;
        if (pressed != level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                level_d = ~level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        single_hit = 1'b0;
        long_hit   = 1'b0;
        dbl_d      = 1'b0;
        case (state_q)
            S_IDLE:   if (rise) state_d = S_PRESS1;
            S_PRESS1: begin
                if (fall) begin
                    state_d = S_WAIT2;
                end else if (timer_q == LONG_LAST) begin
                    long_hit = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            // A second press arriving on the timeout cycle still counts as a double click.
            S_WAIT2: begin
                if (rise) begin
                    state_d = S_PRESS2;
                end else if (timer_q == DC_LAST) begin
                    single_hit = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_PRESS2: begin
                if (fall) begin
                    dbl_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_HOLD:   if (fall) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == {TMR_W{1'b1}}) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            deb_cnt_q    <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            timer_q      <= '0;
            dbl_q        <= 1'b0;
        end else begin
            sync1_q      <= usr_btn;
            sync2_q      <= sync1_q;
            deb_cnt_q    <= deb_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            state_q      <= state_d;
            timer_q      <= timer_d;
            dbl_q        <= dbl_d;
        end
    end

    assign btn_level    = level_q;
    assign single_click = single_hit & rst_n;
    assign long_press   = long_hit & rst_n;
    assign double_click = dbl_q;

`ifdef BTN_CLICK_STATS_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((single_click | double_click | long_press) && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign click_cnt = cnt_q;
`else
    assign click_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_btn_click_decoder.sv
// tb/tb_btn_click_decoder.sv - self-checking bench for btn_click_decoder
module tb_btn_click_decoder;

    localparam int DEB  = 4;
    localparam int DC   = 20;
    localparam int LNG  = 50;
    localparam int MAXN = 1000;
    localparam int BIG  = 1 << 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       usr_btn = 1'b0;
    logic       btn_level, single_click, double_click, long_press;
    logic [7:0] click_cnt;

    int tests = 0;
    int fails = 0;

    logic       pin_a [MAXN];
    logic       o_lvl [MAXN];
    logic       o_s   [MAXN];
    logic       o_d   [MAXN];
    logic       o_l   [MAXN];
    logic [7:0] o_cnt [MAXN];
    logic       e_lvl [MAXN];
    logic       e_s   [MAXN];
    logic       e_d   [MAXN];
    logic       e_l   [MAXN];
    logic [7:0] e_cnt [MAXN];

    btn_click_decoder #(
        .CLK_FREQUENCY     (1000),
        .BUTTON_LOGIC_LEVEL(1),
        .DEBOUNCE_MS       (4),
        .DOUBLE_CLICK_MS   (20),
        .LONG_PRESS_MS     (50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .usr_btn     (usr_btn),
        .btn_level   (btn_level),
        .single_click(single_click),
        .double_click(double_click),
        .long_press  (long_press),
        .click_cnt   (click_cnt)
    );

    always #5 clk = ~clk;

    task automatic fill(input int a, input int b, input logic v);
        for (int i = a; i <= b; i++) pin_a[i] = v;
    endtask

    // Cycle 0 is the cycle opened by the last reset edge; pin_a[c] is driven during cycle c.
    task automatic record(input int n);
        rst_n   = 1'b0;
        usr_btn = pin_a[0];
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < n; c++) begin
            o_lvl[c] = btn_level;
            o_s[c]   = single_click;
            o_d[c]   = double_click;
            o_l[c]   = long_press;
            o_cnt[c] = click_cnt;
            rst_n    = 1'b1;
            usr_btn  = pin_a[c];
            @(negedge clk);
        end
    endtask

    // Reference: level from a sliding window on the 2-cycle-delayed pin, gestures from press/release times.
    task automatic model(input int n);
        int   rs[$];
        int   fs[$];
        int   idx, r, f, t;
        logic diff, s;
        for (int c = 0; c < n; c++) begin
            e_s[c] = 1'b0; e_d[c] = 1'b0; e_l[c] = 1'b0;
        end
        e_lvl[0] = 1'b0;
        for (int c = 0; c < n - 1; c++) begin
            diff = (c >= DEB - 1);
            for (int k = 0; k < DEB; k++) begin
                s = (c - k >= 2) ? pin_a[c - k - 2] : 1'b0;
                if (s == e_lvl[c]) diff = 1'b0;
            end
            e_lvl[c + 1] = diff ? ~e_lvl[c] : e_lvl[c];
        end
        for (int c = 1; c < n; c++) begin
            if (e_lvl[c] && !e_lvl[c - 1]) rs.push_back(c);
            if (!e_lvl[c] && e_lvl[c - 1]) fs.push_back(c);
        end
        idx = 0;
        while (idx < rs.size()) begin
            r = rs[idx];
            f = (idx < fs.size()) ? fs[idx] : BIG;
            if (f > r + LNG) begin
                if (r + LNG < n) e_l[r + LNG] = 1'b1;
                idx += 1;
            end else if (idx + 1 < rs.size() && rs[idx + 1] <= f + DC) begin
                t = (idx + 1 < fs.size()) ? fs[idx + 1] + 1 : BIG;
                if (t < n) e_d[t] = 1'b1;
                idx += 2;
            end else begin
                if (f + DC < n) e_s[f + DC] = 1'b1;
                idx += 1;
            end
        end
        e_cnt[0] = 8'd0;
        for (int c = 0; c < n - 1; c++) begin
`ifdef BTN_CLICK_STATS_EN
            e_cnt[c + 1] = ((e_s[c] | e_d[c] | e_l[c]) && e_cnt[c] != 8'd255) ? e_cnt[c] + 8'd1 : e_cnt[c];
`else
            e_cnt[c + 1] = 8'd0;
`endif
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        usr_btn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({btn_level, single_click, double_click, long_press, click_cnt} !== 12'h000) begin
            fails++;
            $display("FAIL reset outputs got %b%b%b%b,%0d want 0000,0", btn_level, single_click, double_click, long_press, click_cnt);
        end
    endtask

    task automatic test_glitch();
        int n = 60, nf = 0, hi = 0, np = 0;
        fill(0, n - 1, 1'b0); fill(2, 4, 1'b1);
        record(n); model(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if ({o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c]} !== {e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]}) begin
                fails++; nf++;
                if (nf <= 4) $display("FAIL glitch cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", c, o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c], e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]);
            end
            hi += o_lvl[c];
            np += o_s[c] + o_d[c] + o_l[c];
        end
        tests++;
        if (hi != 0 || np != 0) begin
            fails++;
            $display("FAIL glitch_quiet level-high cycles %0d pulses %0d want 0 0", hi, np);
        end
    endtask

    task automatic test_single();
        int n = 60, nf = 0, ns = 0, first = -1;
        fill(0, n - 1, 1'b0); fill(2, 11, 1'b1);
        record(n); model(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if ({o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c]} !== {e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]}) begin
                fails++; nf++;
                if (nf <= 4) $display("FAIL single cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", c, o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c], e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]);
            end
            if (o_s[c]) begin
                ns++;
                if (first < 0) first = c;
            end
        end
        // Release pin at 12 -> fall strobe at 12+2+DEB = 18 -> single 20 cycles later.
        tests++;
        if (ns != 1 || first != 18 + DC) begin
            fails++;
            $display("FAIL single_timing count %0d at cyc %0d want 1 at %0d", ns, first, 18 + DC);
        end
    endtask

    task automatic test_double();
        int n = 70, nf = 0, nd = 0, ns = 0, first = -1;
        fill(0, n - 1, 1'b0); fill(2, 11, 1'b1); fill(20, 29, 1'b1);
        record(n); model(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if ({o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c]} !== {e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]}) begin
                fails++; nf++;
                if (nf <= 4) $display("FAIL double cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", c, o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c], e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]);
            end
            ns += o_s[c];
            if (o_d[c]) begin
                nd++;
                if (first < 0) first = c;
            end
        end
        tests++;
        if (nd != 1 || ns != 0 || first != 37) begin
            fails++;
            $display("FAIL double_timing dbl %0d at cyc %0d singles %0d want 1 at 37 singles 0", nd, first, ns);
        end
    endtask

    task automatic test_long();
        int n = 120, nf = 0, nl = 0, np = 0, first = -1;
        fill(0, n - 1, 1'b0); fill(2, 81, 1'b1);
        record(n); model(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if ({o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c]} !== {e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]}) begin
                fails++; nf++;
                if (nf <= 4) $display("FAIL long cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", c, o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c], e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]);
            end
            np += o_s[c] + o_d[c];
            if (o_l[c]) begin
                nl++;
                if (first < 0) first = c;
            end
        end
        tests++;
        if (nl != 1 || np != 0 || first != 8 + LNG) begin
            fails++;
            $display("FAIL long_timing long %0d at cyc %0d other %0d want 1 at %0d other 0", nl, first, np, 8 + LNG);
        end
    endtask

    task automatic test_boundary();
        int n = 100, nf = 0, nd = 0, ns = 0;
        // Gap of DC and of DC+1 low cycles: rise exactly on / one after the WAIT2 timeout.
        for (int g = DC; g <= DC + 1; g++) begin
            fill(0, n - 1, 1'b0); fill(2, 11, 1'b1); fill(12 + g, 21 + g, 1'b1);
            record(n); model(n);
            nd = 0; ns = 0;
            for (int c = 0; c < n; c++) begin
                tests++;
                if ({o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c]} !== {e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]}) begin
                    fails++; nf++;
                    if (nf <= 4) $display("FAIL boundary gap %0d cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", g, c, o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c], e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]);
                end
                nd += o_d[c];
                ns += o_s[c];
            end
            tests++;
            if ((g == DC && (nd != 1 || ns != 0)) || (g != DC && (nd != 0 || ns != 2))) begin
                fails++;
                $display("FAIL boundary_kind gap %0d doubles %0d singles %0d want %0d %0d", g, nd, ns, (g == DC) ? 1 : 0, (g == DC) ? 0 : 2);
            end
        end
    endtask

    task automatic test_held_reset();
        int n = 80, nf = 0, rise_at = -1;
        fill(0, n - 1, 1'b0); fill(0, 29, 1'b1);
        record(n); model(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if ({o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c]} !== {e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]}) begin
                fails++; nf++;
                if (nf <= 4) $display("FAIL held cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", c, o_lvl[c], o_s[c], o_d[c], o_l[c], o_cnt[c], e_lvl[c], e_s[c], e_d[c], e_l[c], e_cnt[c]);
            end
            if (o_lvl[c] && rise_at < 0) rise_at = c;
        end
        tests++;
        if (rise_at != DEB + 2) begin
            fails++;
            $display("FAIL held_rise level first high at cyc %0d want %0d", rise_at, DEB + 2);
        end
    endtask

    task automatic test_reset_mid();
        int saw_hi = 0, bad = 0;
        rst_n = 1'b0; usr_btn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            saw_hi += btn_level;
            if (single_click | double_click | long_press) bad++;
            usr_btn = (c < 10);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            tests++;
            if ({btn_level, single_click, double_click, long_press, click_cnt} !== 12'h000) begin
                fails++;
                $display("FAIL reset_mid in-reset cyc %0d got %b%b%b%b,%0d want 0000,0", c, btn_level, single_click, double_click, long_press, click_cnt);
            end
            if (c == 2) rst_n = 1'b1;
            @(negedge clk);
        end
        for (int c = 0; c < 40; c++) begin
            if (btn_level | single_click | double_click | long_press | (click_cnt != 8'd0)) bad++;
            @(negedge clk);
        end
        tests++;
        if (saw_hi == 0 || bad != 0) begin
            fails++;
            $display("FAIL reset_mid press seen %0d stray activity %0d want >0 and 0", saw_hi, bad);
        end
    endtask

    task automatic test_random();
        int n = 800, nf = 0, c, len;
        logic v;
        for (int it = 0; it < 5; it++) begin
            c = 0; v = 1'b0;
            while (c < n) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 70);
                for (int k = 0; k < len && c < n; k++) begin
                    pin_a[c] = v;
                    c++;
                end
                v = ~v;
            end
            record(n); model(n);
            for (int j = 0; j < n; j++) begin
                tests++;
                if ({o_lvl[j], o_s[j], o_d[j], o_l[j], o_cnt[j]} !== {e_lvl[j], e_s[j], e_d[j], e_l[j], e_cnt[j]}) begin
                    fails++; nf++;
                    if (nf <= 4) $display("FAIL random it %0d cyc %0d lvl,s,d,l,cnt got %b%b%b%b,%0d want %b%b%b%b,%0d", it, j, o_lvl[j], o_s[j], o_d[j], o_l[j], o_cnt[j], e_lvl[j], e_s[j], e_d[j], e_l[j], e_cnt[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_double();
        test_long();
        test_boundary();
        test_held_reset();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
